// File: rtl/cache_miss_sequencer.sv
// Lookup/miss control stage in front of the 4-way tag store: tracks tree
// pseudo-LRU per set, sequences victim read-back, fill/evict handshake and tag write.
module cache_miss_sequencer #(
  parameter int TAG_BITS  = 13,
  parameter int SET_BITS  = 9,
  parameter int LINE_BITS = 4
) (
  input  logic                                  main_clk,
  input  logic                                  main_rst,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [TAG_BITS+SET_BITS+LINE_BITS-1:0] req_address,
  output logic                                  resp_valid,
  output logic                                  resp_hit,
  output logic [1:0]                            resp_way,
  output logic [TAG_BITS+SET_BITS+LINE_BITS-1:0] tag_target_address,
  output logic [1:0]                            tag_in_way_index,
  output logic                                  tag_do_write,
  input  logic                                  tag_fault,
  input  logic [1:0]                            tag_way_index,
  input  logic [TAG_BITS-1:0]                   tag_addr_at_way,
  output logic                                  fill_valid,
  input  logic                                  fill_ready,
  output logic [TAG_BITS+SET_BITS+LINE_BITS-1:0] fill_address,
  output logic [TAG_BITS+SET_BITS+LINE_BITS-1:0] fill_evict_address,
  output logic [1:0]                            fill_way,
  input  logic                                  fill_done
);

  localparam int ADDR_BITS = TAG_BITS + SET_BITS + LINE_BITS;
  localparam int NUM_SETS  = 1 << SET_BITS;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, CHECK, VICTIM, EVICT_RD, FILL_REQ, FILL_WAIT, TAG_WRITE
  } state_t;

  state_t               state, next_state;
  logic [ADDR_BITS-1:0] addr_r;
  logic [1:0]           victim_r;
  logic [TAG_BITS-1:0]  evict_tag;
  logic [2:0]           plru [NUM_SETS];
  logic [SET_BITS-1:0]  set_idx;
  logic [1:0]           cur_victim;
  logic                 touch_en;
  logic [1:0]           touch_way;

  // Tree PLRU {b2,b1,b0}: b0 picks the pair, b1/b2 pick within the pair.
  function automatic logic [1:0] plru_victim(input logic [2:0] bits);
    if (!bits[0]) return {1'b0, bits[1]};
    else          return {1'b1, bits[2]};
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [1:0] way);
    logic [2:0] r;
    r    = bits;
    r[0] = ~way[1];
    if (!way[1]) r[1] = (way == 2'd0);
    else         r[2] = (way == 2'd2);
    return r;
  endfunction

  assign set_idx            = addr_r[LINE_BITS +: SET_BITS];
  assign cur_victim         = plru_victim(plru[set_idx]);
  assign tag_target_address = addr_r;
  assign fill_address       = {addr_r[ADDR_BITS-1:LINE_BITS], {LINE_BITS{1'b0}}};
  assign fill_evict_address = {evict_tag, set_idx, {LINE_BITS{1'b0}}};
  assign fill_way           = victim_r;

  always_ff @(posedge main_clk or posedge main_rst) begin
    if (main_rst) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (req_valid) next_state = LOOKUP;
      LOOKUP:    next_state = CHECK;
      CHECK:     next_state = tag_fault ? VICTIM : IDLE;
      VICTIM:    next_state = EVICT_RD;
      EVICT_RD:  next_state = FILL_REQ;
      FILL_REQ:  if (fill_ready) next_state = FILL_WAIT;
      FILL_WAIT: if (fill_done) next_state = TAG_WRITE;
      TAG_WRITE: next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_hit         = 1'b0;
    resp_way         = 2'd0;
    tag_in_way_index = 2'd0;
    tag_do_write     = 1'b0;
    fill_valid       = 1'b0;
    touch_en         = 1'b0;
    touch_way        = 2'd0;
    case (state)
      IDLE: req_ready = 1'b1;
      CHECK: begin
        if (tag_fault) begin
          // Victim goes to the tag store now so its stored tag is readable two cycles on.
          tag_in_way_index = cur_victim;
        end else begin
          resp_valid = 1'b1;
          resp_hit   = 1'b1;
          resp_way   = tag_way_index;
          touch_en   = 1'b1;
          touch_way  = tag_way_index;
        end
      end
      VICTIM, EVICT_RD, FILL_WAIT: tag_in_way_index = victim_r;
      FILL_REQ: begin
        tag_in_way_index = victim_r;
        fill_valid       = 1'b1;
      end
      TAG_WRITE: begin
        tag_in_way_index = victim_r;
        tag_do_write     = 1'b1;
        resp_valid       = 1'b1;
        resp_way         = victim_r;
        touch_en         = 1'b1;
        touch_way        = victim_r;
      end
      default: ;
    endcase
  end

  always_ff @(posedge main_clk or posedge main_rst) begin
    if (main_rst) begin
      addr_r    <= '0;
      victim_r  <= '0;
      evict_tag <= '0;
      for (int i = 0; i < NUM_SETS; i++) plru[i] <= '0;
    end else begin
      if (state == IDLE && req_valid) addr_r <= req_address;
      if (state == CHECK && tag_fault) victim_r <= cur_victim;
      if (state == EVICT_RD) evict_tag <= tag_addr_at_way;
      if (touch_en) plru[set_idx] <= plru_touch(plru[set_idx], touch_way);
    end
  end

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Directed bench for cache_miss_sequencer with a behavioural 4-way tag store
// (registered outputs) and hand-driven fill handshake.
module tb_cache_miss_sequencer;

  logic        main_clk = 1'b0;
  logic        main_rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [25:0] req_address = '0;
  logic        resp_valid;
  logic        resp_hit;
  logic [1:0]  resp_way;
  logic [25:0] tag_target_address;
  logic [1:0]  tag_in_way_index;
  logic        tag_do_write;
  logic        tag_fault = 1'b1;
  logic [1:0]  tag_way_index = '0;
  logic [12:0] tag_addr_at_way = '0;
  logic        fill_valid;
  logic        fill_ready = 1'b0;
  logic [25:0] fill_address;
  logic [25:0] fill_evict_address;
  logic [1:0]  fill_way;
  logic        fill_done = 1'b0;

  int checks = 0;
  int passes = 0;

  // Tag store model controls
  logic        mem_clear = 1'b1;
  logic        preload_en = 1'b0;
  logic [8:0]  preload_set = '0;
  logic [1:0]  preload_way = '0;
  logic [12:0] preload_tag = '0;
  logic [12:0] tag_mem [512][4];
  logic [1:0]  in_way_r = '0;

  cache_miss_sequencer dut (
    .main_clk(main_clk), .main_rst(main_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_address(req_address),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .tag_target_address(tag_target_address), .tag_in_way_index(tag_in_way_index),
    .tag_do_write(tag_do_write), .tag_fault(tag_fault), .tag_way_index(tag_way_index),
    .tag_addr_at_way(tag_addr_at_way),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_address(fill_address),
    .fill_evict_address(fill_evict_address), .fill_way(fill_way), .fill_done(fill_done)
  );

  always #5 main_clk = ~main_clk;

  always @(posedge main_clk) begin : tag_model
    logic        found;
    logic [1:0]  hw;
    logic [12:0] t;
    logic [8:0]  s;
    t = tag_target_address[25:13];
    s = tag_target_address[12:4];
    found = 1'b0;
    hw = 2'd0;
    for (int w = 3; w >= 0; w--) begin
      if (tag_mem[s][w] == t) begin
        found = 1'b1;
        hw = w[1:0];
      end
    end
    tag_fault       <= !found;
    tag_way_index   <= hw;
    tag_addr_at_way <= tag_mem[s][tag_in_way_index];
    in_way_r        <= tag_in_way_index;
    if (mem_clear) begin
      for (int i = 0; i < 512; i++)
        for (int w = 0; w < 4; w++) tag_mem[i][w] <= '0;
    end else begin
      if (preload_en) tag_mem[preload_set][preload_way] <= preload_tag;
      if (tag_do_write) tag_mem[s][in_way_r] <= t;
    end
  end

  task automatic apply_reset();
    main_rst = 1'b1;
    mem_clear = 1'b1;
    req_valid = 1'b0;
    fill_ready = 1'b0;
    fill_done = 1'b0;
    preload_en = 1'b0;
    repeat (2) @(negedge main_clk);
    main_rst = 1'b0;
    mem_clear = 1'b0;
    @(negedge main_clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b want=1", req_ready);
    else passes++;
    checks++;
    if ({resp_valid, resp_hit, resp_way, fill_valid, tag_do_write, tag_in_way_index} !== 8'd0)
      $display("FAIL reset_outputs got=%b want=0",
               {resp_valid, resp_hit, resp_way, fill_valid, tag_do_write, tag_in_way_index});
    else passes++;
    checks++;
    if ({tag_target_address, fill_address, fill_evict_address, fill_way} !== 80'd0)
      $display("FAIL reset_addresses got=%h/%h/%h/%h want=0",
               tag_target_address, fill_address, fill_evict_address, fill_way);
    else passes++;
  endtask

  task automatic test_hit();
    apply_reset();
    preload_en = 1'b1;
    preload_set = 9'h05A;
    preload_way = 2'd1;
    preload_tag = 13'h1ABC;
    @(negedge main_clk);
    preload_en = 1'b0;
    req_address = 26'h35785A0;
    req_valid = 1'b1;
    @(negedge main_clk);
    req_valid = 1'b0;
    checks++;
    if ({req_ready, resp_valid} !== 2'b00 || tag_target_address !== 26'h35785A0)
      $display("FAIL hit_lookup got=rdy%b rv%b addr%h want=rdy0 rv0 addr35785a0",
               req_ready, resp_valid, tag_target_address);
    else passes++;
    @(negedge main_clk);
    checks++;
    if ({resp_valid, resp_hit, resp_way} !== 4'b1101)
      $display("FAIL hit_resp got=v%b h%b w%0d want=v1 h1 w1", resp_valid, resp_hit, resp_way);
    else passes++;
    @(negedge main_clk);
    checks++;
    if (dut.plru[9'h05A] !== 3'b001)
      $display("FAIL hit_plru got=%b want=001", dut.plru[9'h05A]);
    else passes++;
    checks++;
    if ({req_ready, resp_valid} !== 2'b10)
      $display("FAIL hit_back_idle got=rdy%b rv%b want=rdy1 rv0", req_ready, resp_valid);
    else passes++;
  endtask

  task automatic do_miss(input logic [25:0] addr, input logic [25:0] exp_fill,
                         input logic [1:0] exp_way, input logic [25:0] exp_evict,
                         input logic [12:0] exp_tag);
    int n;
    req_address = addr;
    req_valid = 1'b1;
    @(negedge main_clk);
    req_valid = 1'b0;
    @(negedge main_clk);
    checks++;
    if (resp_valid !== 1'b0 || tag_in_way_index !== exp_way)
      $display("FAIL miss_check got=rv%b idx%0d want=rv0 idx%0d", resp_valid, tag_in_way_index, exp_way);
    else passes++;
    n = 0;
    while (fill_valid !== 1'b1 && n < 20) begin
      @(negedge main_clk);
      n++;
    end
    checks++;
    if (n !== 3) $display("FAIL miss_fill_latency got=%0d want=3", n);
    else passes++;
    checks++;
    if (fill_address !== exp_fill || fill_evict_address !== exp_evict || fill_way !== exp_way)
      $display("FAIL miss_fill_fields got=%h/%h/%0d want=%h/%h/%0d",
               fill_address, fill_evict_address, fill_way, exp_fill, exp_evict, exp_way);
    else passes++;
    fill_ready = 1'b1;
    @(negedge main_clk);
    fill_ready = 1'b0;
    checks++;
    if (fill_valid !== 1'b0) $display("FAIL miss_fill_drop got=%b want=0", fill_valid);
    else passes++;
    fill_done = 1'b1;
    @(negedge main_clk);
    fill_done = 1'b0;
    checks++;
    if ({tag_do_write, resp_valid, resp_hit, resp_way} !== {3'b110, exp_way})
      $display("FAIL miss_resp got=wr%b v%b h%b w%0d want=wr1 v1 h0 w%0d",
               tag_do_write, resp_valid, resp_hit, resp_way, exp_way);
    else passes++;
    @(negedge main_clk);
    checks++;
    if (tag_do_write !== 1'b0 || req_ready !== 1'b1 || tag_mem[addr[12:4]][exp_way] !== exp_tag)
      $display("FAIL miss_written got=wr%b rdy%b tag%h want=wr0 rdy1 tag%h",
               tag_do_write, req_ready, tag_mem[addr[12:4]][exp_way], exp_tag);
    else passes++;
  endtask

  task automatic test_miss();
    apply_reset();
    do_miss(26'h0400120, 26'h0400120, 2'd0, 26'h0000120, 13'h200);
  endtask

  task automatic test_plru_sequence();
    apply_reset();
    do_miss(26'h0602128, 26'h0602120, 2'd0, 26'h0000120, 13'h301);
    do_miss(26'h0604120, 26'h0604120, 2'd2, 26'h0000120, 13'h302);
    do_miss(26'h0606120, 26'h0606120, 2'd1, 26'h0000120, 13'h303);
    do_miss(26'h0608120, 26'h0608120, 2'd3, 26'h0000120, 13'h304);
    do_miss(26'h060A120, 26'h060A120, 2'd0, 26'h0602120, 13'h305);
  endtask

  task automatic test_fill_stall();
    int n;
    int bad;
    apply_reset();
    req_address = 26'h0400120;
    req_valid = 1'b1;
    @(negedge main_clk);
    req_valid = 1'b0;
    n = 0;
    while (fill_valid !== 1'b1 && n < 20) begin
      @(negedge main_clk);
      n++;
    end
    checks++;
    if (fill_valid !== 1'b1) $display("FAIL stall_fill_timeout got=%b want=1", fill_valid);
    else passes++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      fill_done = (i == 3);
      @(negedge main_clk);
      if (fill_valid !== 1'b1 || fill_address !== 26'h0400120 ||
          fill_evict_address !== 26'h0000120 || fill_way !== 2'd0 || resp_valid !== 1'b0)
        bad++;
    end
    fill_done = 1'b0;
    checks++;
    if (bad !== 0) $display("FAIL stall_hold got=%0d bad cycles want=0", bad);
    else passes++;
    fill_ready = 1'b1;
    @(negedge main_clk);
    fill_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (fill_valid !== 1'b0 || resp_valid !== 1'b0 || tag_do_write !== 1'b0) bad++;
      @(negedge main_clk);
    end
    checks++;
    if (bad !== 0) $display("FAIL stall_wait got=%0d bad cycles want=0", bad);
    else passes++;
    fill_done = 1'b1;
    @(negedge main_clk);
    fill_done = 1'b0;
    checks++;
    if ({tag_do_write, resp_valid, resp_hit, resp_way} !== 5'b11000)
      $display("FAIL stall_resp got=wr%b v%b h%b w%0d want=wr1 v1 h0 w0",
               tag_do_write, resp_valid, resp_hit, resp_way);
    else passes++;
    @(negedge main_clk);
  endtask

  task automatic test_reset_mid();
    int n;
    int bad;
    apply_reset();
    do_miss(26'h0400120, 26'h0400120, 2'd0, 26'h0000120, 13'h200);
    req_address = 26'h0602120;
    req_valid = 1'b1;
    @(negedge main_clk);
    req_valid = 1'b0;
    n = 0;
    while (fill_valid !== 1'b1 && n < 20) begin
      @(negedge main_clk);
      n++;
    end
    checks++;
    if (fill_valid !== 1'b1 || fill_way !== 2'd2)
      $display("FAIL rstmid_fill got=v%b w%0d want=v1 w2", fill_valid, fill_way);
    else passes++;
    fill_ready = 1'b1;
    @(negedge main_clk);
    fill_ready = 1'b0;
    checks++;
    if (dut.plru[9'h012] !== 3'b011) $display("FAIL rstmid_plru_before got=%b want=011", dut.plru[9'h012]);
    else passes++;
    #2 main_rst = 1'b1;
    #1;
    checks++;
    if ({fill_valid, req_ready, resp_valid, tag_do_write} !== 4'b0100)
      $display("FAIL rstmid_async got=fv%b rdy%b rv%b wr%b want=fv0 rdy1 rv0 wr0",
               fill_valid, req_ready, resp_valid, tag_do_write);
    else passes++;
    fill_done = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge main_clk);
      if (resp_valid !== 1'b0) bad++;
    end
    fill_done = 1'b0;
    main_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge main_clk);
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL rstmid_no_resp got=%0d bad cycles want=0", bad);
    else passes++;
    bad = 0;
    for (int i = 0; i < 512; i++) if (dut.plru[i] !== 3'b000) bad++;
    checks++;
    if (bad !== 0) $display("FAIL rstmid_plru_clear got=%0d nonzero sets want=0", bad);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int n;
    apply_reset();
    req_address = 26'h0400120;
    req_valid = 1'b1;
    @(negedge main_clk);
    req_address = 26'h0400124;
    n = 0;
    while (fill_valid !== 1'b1 && n < 20) begin
      @(negedge main_clk);
      n++;
    end
    checks++;
    if (fill_valid !== 1'b1 || tag_target_address !== 26'h0400120 || req_ready !== 1'b0)
      $display("FAIL b2b_hold got=fv%b addr%h rdy%b want=fv1 addr0400120 rdy0",
               fill_valid, tag_target_address, req_ready);
    else passes++;
    fill_ready = 1'b1;
    @(negedge main_clk);
    fill_ready = 1'b0;
    fill_done = 1'b1;
    @(negedge main_clk);
    fill_done = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || req_ready !== 1'b0 || tag_target_address !== 26'h0400120)
      $display("FAIL b2b_first_resp got=rv%b rdy%b addr%h want=rv1 rdy0 addr0400120",
               resp_valid, req_ready, tag_target_address);
    else passes++;
    @(negedge main_clk);
    checks++;
    if (req_ready !== 1'b1 || tag_target_address !== 26'h0400120)
      $display("FAIL b2b_idle got=rdy%b addr%h want=rdy1 addr0400120", req_ready, tag_target_address);
    else passes++;
    @(negedge main_clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || tag_target_address !== 26'h0400124)
      $display("FAIL b2b_second_accept got=rdy%b addr%h want=rdy0 addr0400124", req_ready, tag_target_address);
    else passes++;
    @(negedge main_clk);
    checks++;
    if ({resp_valid, resp_hit, resp_way} !== 4'b1100)
      $display("FAIL b2b_second_hit got=v%b h%b w%0d want=v1 h1 w0", resp_valid, resp_hit, resp_way);
    else passes++;
    @(negedge main_clk);
  endtask

  initial begin
    $display("[TB] cache_miss_sequencer directed tests");
    test_reset();
    test_hit();
    test_miss();
    test_plru_sequence();
    test_fill_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
